// File: rtl/snake_txt_pkg.sv
// rtl/snake_txt_pkg.sv - shared constants and types for the txt_* text ROMs and renderers
package snake_txt_pkg;

    localparam int XY_W = 8;
    localparam int CODE_W = 7;
    localparam logic [CODE_W-1:0] CHAR_BLANK = 7'h20;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } txt_arb_state_t;

endpackage

// File: rtl/txt_rr_picker.sv
// rtl/txt_rr_picker.sv - combinational rotating-priority one-hot picker
module txt_rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot
);

    logic w_found;

    // Priority rank k visits client (ptr+k) mod N; the first requester wins.
    always_comb begin
        o_onehot = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int c = 0; c < N; c++) begin
                if (!w_found && i_req[c] && (c == (int'(i_ptr) + k) % N)) begin
                    o_onehot[c] = 1'b1;
                    w_found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/txt_rom_arbiter.sv
// rtl/txt_rom_arbiter.sv - round-robin arbiter with burst lock sharing one text ROM
module txt_rom_arbiter
    import snake_txt_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int ROM_LAT   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_lock,
    input  logic [N_REQ*XY_W-1:0]   i_req_xy,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [XY_W-1:0]         o_rom_xy,
    input  logic [CODE_W-1:0]       i_rom_code,
    output logic [N_REQ-1:0]        o_rsp_valid,
    output logic [CODE_W-1:0]       o_rsp_code,
    output logic                    o_busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    txt_arb_state_t                     r_state, w_state_nxt;
    logic [PTR_W-1:0]                   r_owner, w_owner_nxt;
    logic [PTR_W-1:0]                   r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0]                   r_burst_cnt, w_burst_cnt_nxt;
    logic [ROM_LAT-1:0][N_REQ-1:0]      r_tag;

    logic [N_REQ-1:0] w_pick;
    logic [N_REQ-1:0] w_gnt;
    logic [N_REQ-1:0] w_owner_oh;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_gnt_inc;
    logic [PTR_W-1:0] w_owner_inc;
    logic [XY_W-1:0]  w_rom_xy;
    logic             w_xfer;
    logic             w_gnt_lock;
    logic             w_owner_req;
    logic             w_owner_lock;
    logic             w_release;

    txt_rr_picker #(.N(N_REQ), .PTR_W(PTR_W)) u_picker (
        .i_req    (i_req),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick)
    );

    assign w_owner_oh   = N_REQ'(1) << r_owner;
    assign w_owner_req  = |(w_owner_oh & i_req);
    assign w_owner_lock = |(w_owner_oh & i_lock);

    always_comb begin
        w_gnt = '0;
        if (i_rst_n) begin
            if (r_state == ARB) w_gnt = w_pick;
            else                w_gnt = w_owner_oh & i_req;
        end
    end

    always_comb begin
        w_gnt_idx = '0;
        w_rom_xy  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = PTR_W'(i);
                w_rom_xy  = i_req_xy[i*XY_W +: XY_W];
            end
        end
    end

    assign w_xfer      = |w_gnt;
    assign w_gnt_lock  = |(w_gnt & i_lock);
    assign w_gnt_inc   = (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    assign w_owner_inc = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        w_release       = 1'b0;
        case (r_state)
            ARB: begin
                if (w_xfer) begin
                    if (w_gnt_lock && (MAX_BURST > 1)) begin
                        w_state_nxt     = LOCKED;
                        w_owner_nxt     = w_gnt_idx;
                        w_burst_cnt_nxt = CNT_W'(1);
                    end else begin
                        w_rr_ptr_nxt = w_gnt_inc;
                    end
                end
            end
            LOCKED: begin
                // Owner idling with lock held keeps the ROM as a bubble cycle.
                if (w_owner_req) begin
                    if (w_owner_lock && ((r_burst_cnt + CNT_W'(1)) != CNT_W'(MAX_BURST)))
                        w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
                    else
                        w_release = 1'b1;
                end else if (!w_owner_lock) begin
                    w_release = 1'b1;
                end
            end
            default: w_release = 1'b1;
        endcase
        if (w_release) begin
            w_state_nxt     = ARB;
            w_rr_ptr_nxt    = w_owner_inc;
            w_burst_cnt_nxt = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ARB;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_tag       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_tag[0]    <= w_gnt;
            for (int k = 1; k < ROM_LAT; k++) r_tag[k] <= r_tag[k-1];
        end
    end

    // Gating with rst_n keeps the outputs at their reset values throughout reset.
    assign o_gnt       = w_gnt;
    assign o_rom_xy    = w_rom_xy;
    assign o_rsp_valid = r_tag[ROM_LAT-1] & {N_REQ{i_rst_n}};
    assign o_rsp_code  = i_rom_code;
    assign o_busy      = i_rst_n & ((r_state == LOCKED) | (|r_tag));

endmodule

// File: tb/tb_txt_rom_arbiter.sv
// tb/tb_txt_rom_arbiter.sv - self-checking bench for txt_rom_arbiter
module tb_txt_rom_arbiter;
    import snake_txt_pkg::*;

    localparam int N   = 4;
    localparam int MB  = 16;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req, lock, gnt, rsp_valid;
    logic [N*8-1:0] req_xy;
    logic [7:0]    rom_xy;
    logic [6:0]    rom_code, rsp_code;
    logic          busy;

    always #5 clk = ~clk;

    txt_rom_arbiter #(.N_REQ(N), .MAX_BURST(MB), .ROM_LAT(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_lock(lock), .i_req_xy(req_xy),
        .o_gnt(gnt), .o_rom_xy(rom_xy), .i_rom_code(rom_code),
        .o_rsp_valid(rsp_valid), .o_rsp_code(rsp_code), .o_busy(busy)
    );

    function automatic logic [6:0] rom_func(input logic [7:0] xy);
        string row0;
        row0 = " reset defaults ";
        if (xy[7:4] == 4'h0) begin
            if (xy[3:0] == 4'hF) return CHAR_BLANK;
            return 7'(row0[xy[3:0]]);
        end
        return 7'h40 | {1'b0, xy[5:0]};
    endfunction

    always @(posedge clk) rom_code <= rom_func(rom_xy);

    int total = 0;
    int bad   = 0;
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    logic [N-1:0] m_rsp = '0;
    logic [6:0]   m_code = '0;
    logic [7:0]   xy_arr [N];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One cycle: drive, check mid-cycle against the model, advance the model, cross the edge.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                        output logic [N-1:0] g_got, output logic [7:0] xy_got);
        int g;
        logic [N-1:0] eg;
        logic [7:0] exy;
        bit rel;
        rst_n  = ~r;
        req    = rq;
        lock   = lk;
        req_xy = {xy_arr[3], xy_arr[2], xy_arr[1], xy_arr[0]};
        #4;
        g = -1;
        if (!r) begin
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && rq[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end else if (rq[m_owner]) begin
                g = m_owner;
            end
        end
        eg  = (g >= 0) ? N'(1 << g) : '0;
        exy = (g >= 0) ? xy_arr[g] : 8'h00;
        g_got  = gnt;
        xy_got = rom_xy;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rom_xy", 32'(rom_xy), 32'(exy));
        chk("rsp_valid", 32'(rsp_valid), r ? 32'd0 : 32'(m_rsp));
        chk("busy", 32'(busy), r ? 32'd0 : 32'((m_owner >= 0) || (m_rsp != 0)));
        if (!r && m_rsp != 0) chk("rsp_code", 32'(rsp_code), 32'(m_code));
        if (r) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_rsp = '0;
        end else begin
            m_rsp  = eg;
            m_code = rom_func(exy);
            if (m_owner < 0) begin
                if (g >= 0) begin
                    if (lk[g]) begin m_owner = g; m_cnt = 1; end
                    else m_ptr = (g + 1) % N;
                end
            end else begin
                rel = 0;
                if (rq[m_owner]) begin
                    if (lk[m_owner]) begin m_cnt++; if (m_cnt == MB) rel = 1; end
                    else rel = 1;
                end else if (!lk[m_owner]) rel = 1;
                if (rel) begin m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic [N-1:0] gnt;
    } vec_t;

    vec_t tbl[$];
    logic [N-1:0] gg, prev_rq, rq, lk;
    logic [7:0]   gx;

    initial begin
        xy_arr[0] = 8'h13; xy_arr[1] = 8'h22; xy_arr[2] = 8'h05; xy_arr[3] = 8'h31;
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0000});
        for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'(1 << (i % 4))});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].lock, gg, gx);
            chk($sformatf("tbl_gnt[%0d]", i), 32'(gg), 32'(tbl[i].gnt));
        end

        // Single lookup from client 2 into the settings row.
        step(1'b0, 4'b0100, 4'b0000, gg, gx);
        chk("single_gnt", 32'(gg), 32'h4);
        chk("single_xy", 32'(gx), 32'h05);
        chk("single_rsp", 32'(rsp_valid), 32'h4);
        chk("single_code", 32'(rsp_code), 32'h74);
        step(1'b0, 4'b0000, 4'b0000, gg, gx);

        // Full burst: 16 locked grants to client 0, then client 1, then client 0.
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 4'b0011, 4'b0001, gg, gx);
            chk($sformatf("burst[%0d]", k), 32'(gg), (k == 16) ? 32'h2 : 32'h1);
        end
        step(1'b1, 4'b0000, 4'b0000, gg, gx);

        // Early release on the fifth transfer, then idle-with-lock bubbles.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b1001, (k < 4) ? 4'b0001 : 4'b0000, gg, gx);
            chk($sformatf("early[%0d]", k), 32'(gg), 32'h1);
        end
        step(1'b0, 4'b1001, 4'b0000, gg, gx);
        chk("early_next", 32'(gg), 32'h8);
        step(1'b0, 4'b0001, 4'b0001, gg, gx);
        chk("relock", 32'(gg), 32'h1);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 4'b0010, 4'b0001, gg, gx);
            chk($sformatf("bubble_gnt[%0d]", k), 32'(gg), 32'h0);
            chk($sformatf("bubble_busy[%0d]", k), 32'(busy), 32'h1);
        end
        step(1'b0, 4'b0010, 4'b0000, gg, gx);
        chk("idle_release", 32'(gg), 32'h0);
        step(1'b0, 4'b0010, 4'b0000, gg, gx);
        chk("after_release", 32'(gg), 32'h2);

        // Reset right after a transfer drops its response.
        step(1'b0, 4'b0100, 4'b0000, gg, gx);
        chk("mid_gnt", 32'(gg), 32'h4);
        step(1'b1, 4'b0000, 4'b0000, gg, gx);
        chk("mid_rsp", 32'(rsp_valid), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        step(1'b0, 4'b1010, 4'b0000, gg, gx);
        chk("mid_next", 32'(gg), 32'h2);

        // Randomized traffic against the model, honouring xy stability while waiting.
        prev_rq = 4'b1010;
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < N; i++)
                if (!prev_rq[i] || gg[i]) xy_arr[i] = 8'($urandom);
            rq = 4'($urandom);
            lk = 4'($urandom) | 4'($urandom);
            step(($urandom % 64) == 0, rq, lk, gg, gx);
            prev_rq = rq;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/txt_rom_arbiter.md
Name: txt_rom_arbiter

Overview:
- Shares one single-port text ROM between N_REQ drawing clients, e.g. menu title, settings, score overlay and game-over text renderers.
- Each ROM is a char_xy (8-bit, {row,col} nibbles) -> char_code (7-bit ASCII) lookup with a registered output.
- One lookup is accepted per cycle using round-robin arbitration.
- A client may lock the ROM for a burst of consecutive lookups, up to one text row, to draw a string without interleaving.
- Responses return tagged to the issuing client after the ROM latency.

Parameters:
- N_REQ, 4, number of requesting clients (2..8).
- MAX_BURST, 16, maximum consecutive locked transfers (one 16-char row).
- ROM_LAT, 1, ROM read latency in clock cycles (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  N_REQ  per-client lookup request.
- lock  in  N_REQ  per-client burst-hold hint, sampled on that client's transfer.
- req_xy  in  N_REQ*8  per-client char_xy, packed, client i at [8i+7:8i].
- gnt  out  N_REQ  one-hot/zero; transfer for client i = req[i] & gnt[i].
- rom_xy  out  8  address to shared ROM.
- rom_code  in  7  ROM char_code, valid ROM_LAT cycles after rom_xy.
- rsp_valid  out  N_REQ  one-hot/zero response strobe.
- rsp_code  out  7  response char, passthrough of rom_code.
- busy  out  1  high when in LOCKED state or any lookup is in flight.

Behaviour:
- Clock and reset: single clock domain, clk; rst_n is synchronous, active-low.
- Reset values: gnt=0, rsp_valid=0, busy=0. State=ARB, rr_ptr=0, burst_cnt=0, tag pipeline cleared.
- rom_xy is combinational: req_xy of the granted client, else 8'h00. rsp_code=rom_code at all times.
- Client rule: req_xy stable while req high and not granted. Dropping req without a grant is legal (abort).
- gnt is combinational from req and registered state. gnt[i] is never asserted without req[i]. At most one transfer per cycle.
- ARB state:
  - grant the first requesting client searching from rr_ptr upward, wrapping modulo N_REQ.
  - On transfer from client i: if lock[i]=1 and MAX_BURST>1, go to LOCKED with owner=i and burst_cnt=1.
  - Otherwise rr_ptr<=(i+1) mod N_REQ.
- LOCKED state:
  - only the owner may be granted; other requests stall.
  - Owner transfer with lock=1: burst_cnt++. When the incremented count reaches MAX_BURST, this transfer ends the burst: forced release to ARB, rr_ptr<=owner+1.
  - Owner transfer with lock=0: release to ARB, rr_ptr<=owner+1.
  - Owner req=0 and lock=0: release with no transfer, rr_ptr<=owner+1.
  - Owner req=0 and lock=1: hold the lock, bubble cycle.
  - burst_cnt clears on every return to ARB.
- Response: a transfer at cycle t pushes one-hot tag into a ROM_LAT-deep shift register. rsp_valid equals the tag at cycle t+ROM_LAT. Back-to-back transfers give back-to-back responses in order.
- busy = (state==LOCKED) | any tag in flight.
- Reset mid-operation: in-flight tags are dropped, so no rsp_valid follows. Lock is released and rr_ptr=0.
- burst_cnt width is clog2(MAX_BURST+1). No overflow, because release is forced at MAX_BURST.

Decomposition:
- Package snake_txt_pkg:
  - XY_W=8, CODE_W=7, CHAR_BLANK=7'h20.
  - State enum txt_arb_state_t {ARB, LOCKED}.
  - Shared by all txt_* ROMs and renderers.
- Sub-module txt_rr_picker: combinational rotating-priority one-hot picker with inputs req and ptr and output onehot. It is used in ARB; in LOCKED the owner is masked in directly.

Test Plan:
- Reset: rst_n=0 for 3 cycles with req=4'b1111 -> gnt=0, rsp_valid=0, rom_xy=8'h00, busy=0. After release, first grant goes to client 0.
- Single lookup: req=4'b0100, req_xy[2]=8'h05, settings ROM attached -> same cycle gnt=4'b0100 and rom_xy=8'h05. Next cycle rsp_valid=4'b0100 and rsp_code=7'h74 ("t").
- Round-robin: req=4'b1111 held, lock=0, for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Responses come one cycle later in the same order.
- Full burst: req[0]=req[1]=1, lock[0]=1 held -> 16 consecutive grants to client 0, then client 1, then client 0 again. The 17th client-0 request stalls until client 1 is served.
- Early release: lock[0] dropped on the 5th client-0 transfer with req[3]=1 -> next grant goes to client 3 (search starts at 1) and burst_cnt=0. Owner idle with lock=1 for 2 cycles -> no grants, busy=1.
- Reset mid-flight: rst_n=0 in the cycle after a transfer to client 2 -> rsp_valid stays 0, state=ARB, and the next req=4'b1010 grants client 1.
